// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: operand forwarding, ALU, multi-cycle
// multiply/divide unit with HI/LO, and the EX/MEM pipeline register.
//
// state | meaning
// IDLE  | MD unit free; mult/multu/div/divu launches here, HI/LO readable
// BUSY  | MD op in flight; md_cnt counts remaining edges down to 0
module execute_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rd1_E,
  input  logic [WIDTH-1:0] rd2_E,
  input  logic [WIDTH-1:0] signimm_E,
  input  logic [WIDTH-1:0] result_W,
  input  logic [1:0]       forwardA_E,
  input  logic [1:0]       forwardB_E,
  input  logic [3:0]       alucontrol_E,
  input  logic             alusrc_E,
  input  logic             regdst_E,
  input  logic [4:0]       rt_E,
  input  logic [4:0]       rd_E,
  input  logic             regwrite_E,
  input  logic             memwrite_E,
  input  logic             memtoreg_E,
  input  logic [2:0]       md_op_E,
  output logic             regwrite_M,
  output logic             memwrite_M,
  output logic             memtoreg_M,
  output logic [WIDTH-1:0] aluout_M,
  output logic [WIDTH-1:0] writedata_M,
  output logic [4:0]       writereg_M,
  output logic             md_busy,
  output logic             md_stall
);

  localparam int MAXC = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t        md_state;
  logic [CW-1:0]    md_cnt;
  logic             md_is_div, md_sgn, md_neg_q, md_neg_r, md_dvz;
  logic [WIDTH-1:0] md_quo, md_rem, md_b, md_dvd;
  logic [WIDTH-1:0] hi, lo;

  logic [WIDTH-1:0] srca, fwd_b, srcb, alu_res, ex_res;
  logic             slt_bit, sltu_bit, md_launch, launch_div, launch_sgn;

  always_comb begin
    case (forwardA_E)
      2'b01:   srca = result_W;
      2'b10:   srca = aluout_M;
      default: srca = rd1_E;
    endcase
    case (forwardB_E)
      2'b01:   fwd_b = result_W;
      2'b10:   fwd_b = aluout_M;
      default: fwd_b = rd2_E;
    endcase
  end

  assign srcb     = alusrc_E ? signimm_E : fwd_b;
  assign slt_bit  = $signed(srca) < $signed(srcb);
  assign sltu_bit = srca < srcb;

  always_comb begin
    case (alucontrol_E)
      4'b0000: alu_res = srca & srcb;
      4'b0001: alu_res = srca | srcb;
      4'b0010: alu_res = srca + srcb;
      4'b0110: alu_res = srca - srcb;
      4'b1100: alu_res = ~(srca | srcb);
      4'b1101: alu_res = srca ^ srcb;
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      default: alu_res = '0;
    endcase
  end

  assign ex_res = (md_op_E == 3'b101) ? hi :
                  (md_op_E == 3'b110) ? lo : alu_res;

  assign md_busy    = (md_state == BUSY);
  assign md_stall   = md_busy && (md_op_E != 3'b000) && (md_op_E != 3'b111);
  assign md_launch  = (md_state == IDLE) && (md_op_E >= 3'b001) && (md_op_E <= 3'b100);
  assign launch_div = (md_op_E == 3'b011) || (md_op_E == 3'b100);
  assign launch_sgn = (md_op_E == 3'b001) || (md_op_E == 3'b011);

  // Restoring divide step on magnitudes; md_quo shifts the dividend out and quotient in.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, q_fix, r_fix;

  assign div_shift = {md_rem, md_quo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, md_b};
  assign div_ge    = ~div_diff[WIDTH];
  assign quo_nxt   = {md_quo[WIDTH-2:0], div_ge};
  assign rem_nxt   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign q_fix     = md_neg_q ? -quo_nxt : quo_nxt;
  assign r_fix     = md_neg_r ? -rem_nxt : rem_nxt;

  // Sign/zero extension to 2*WIDTH makes one unsigned multiply serve both kinds.
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, mul_prod;
  assign mul_a_ext = {{WIDTH{md_sgn & md_quo[WIDTH-1]}}, md_quo};
  assign mul_b_ext = {{WIDTH{md_sgn & md_b[WIDTH-1]}}, md_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_state  <= IDLE;
      md_cnt    <= '0;
      md_is_div <= 1'b0;
      md_sgn    <= 1'b0;
      md_neg_q  <= 1'b0;
      md_neg_r  <= 1'b0;
      md_dvz    <= 1'b0;
      md_quo    <= '0;
      md_rem    <= '0;
      md_b      <= '0;
      md_dvd    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else if (md_state == IDLE) begin
      if (md_launch) begin
        md_state  <= BUSY;
        md_is_div <= launch_div;
        md_sgn    <= launch_sgn;
        md_rem    <= '0;
        md_dvd    <= srca;
        md_dvz    <= (fwd_b == '0);
        if (launch_div) begin
          md_cnt   <= CW'(WIDTH - 1);
          md_quo   <= (launch_sgn && srca[WIDTH-1]) ? -srca : srca;
          md_b     <= (launch_sgn && fwd_b[WIDTH-1]) ? -fwd_b : fwd_b;
          md_neg_q <= launch_sgn && (srca[WIDTH-1] ^ fwd_b[WIDTH-1]);
          md_neg_r <= launch_sgn && srca[WIDTH-1];
        end else begin
          md_cnt   <= CW'(MUL_CYCLES - 1);
          md_quo   <= srca;
          md_b     <= fwd_b;
          md_neg_q <= 1'b0;
          md_neg_r <= 1'b0;
        end
      end
    end else begin
      if (md_is_div) begin
        md_quo <= quo_nxt;
        md_rem <= rem_nxt;
      end
      if (md_cnt == '0) begin
        md_state <= IDLE;
        if (!md_is_div) begin
          hi <= mul_prod[2*WIDTH-1:WIDTH];
          lo <= mul_prod[WIDTH-1:0];
        end else if (md_dvz) begin
          hi <= md_dvd;
          lo <= '1;
        end else begin
          hi <= r_fix;
          lo <= q_fix;
        end
      end else begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regwrite_M  <= 1'b0;
      memwrite_M  <= 1'b0;
      memtoreg_M  <= 1'b0;
      aluout_M    <= '0;
      writedata_M <= '0;
      writereg_M  <= '0;
    end else if (md_stall) begin
      regwrite_M <= 1'b0;
      memwrite_M <= 1'b0;
      memtoreg_M <= 1'b0;
    end else begin
      regwrite_M  <= regwrite_E;
      memwrite_M  <= memwrite_E;
      memtoreg_M  <= memtoreg_E;
      aluout_M    <= ex_res;
      writedata_M <= fwd_b;
      writereg_M  <= regdst_E ? rd_E : rt_E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a behavioural model predicts each EX/MEM
// entry, which is queued at issue and compared once the edge has registered it.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd1_E, rd2_E, signimm_E, result_W;
  logic [1:0]  forwardA_E, forwardB_E;
  logic [3:0]  alucontrol_E;
  logic        alusrc_E, regdst_E, regwrite_E, memwrite_E, memtoreg_E;
  logic [4:0]  rt_E, rd_E;
  logic [2:0]  md_op_E;
  logic        regwrite_M, memwrite_M, memtoreg_M, md_busy, md_stall;
  logic [31:0] aluout_M, writedata_M;
  logic [4:0]  writereg_M;

  always #5 clk = ~clk;

  execute_stage #(.WIDTH(32), .MUL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .rd1_E(rd1_E), .rd2_E(rd2_E), .signimm_E(signimm_E),
    .result_W(result_W), .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .alucontrol_E(alucontrol_E), .alusrc_E(alusrc_E), .regdst_E(regdst_E),
    .rt_E(rt_E), .rd_E(rd_E), .regwrite_E(regwrite_E), .memwrite_E(memwrite_E),
    .memtoreg_E(memtoreg_E), .md_op_E(md_op_E), .regwrite_M(regwrite_M),
    .memwrite_M(memwrite_M), .memtoreg_M(memtoreg_M), .aluout_M(aluout_M),
    .writedata_M(writedata_M), .writereg_M(writereg_M), .md_busy(md_busy),
    .md_stall(md_stall)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, mw, mt;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_instr = 0;
  int          md_left = 0;
  logic [31:0] m_alu = 0, m_wd = 0, m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic [4:0]  m_wr = 0;

  localparam logic [3:0] A_AND = 4'b0000, A_OR = 4'b0001, A_ADD = 4'b0010, A_SUB = 4'b0110,
                         A_NOR = 4'b1100, A_XOR = 4'b1101, A_SLT = 4'b0111, A_SLTU = 4'b1001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] ac, input logic [31:0] a, input logic [31:0] b);
    case (ac)
      A_AND:   return a & b;
      A_OR:    return a | b;
      A_ADD:   return a + b;
      A_SUB:   return a - b;
      A_NOR:   return ~(a | b);
      A_XOR:   return a ^ b;
      A_SLT:   return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      A_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s_prod;
    longint unsigned u_prod;
    case (op)
      3'b001: begin
        s_prod = longint'(int'(a)) * longint'(int'(b));
        p_hi = s_prod[63:32]; p_lo = s_prod[31:0]; md_left = 4;
      end
      3'b010: begin
        u_prod = longint'({32'd0, a}) * longint'({32'd0, b});
        p_hi = u_prod[63:32]; p_lo = u_prod[31:0]; md_left = 4;
      end
      default: begin
        md_left = 32;
        if (b == 0) begin
          p_lo = 32'hFFFF_FFFF; p_hi = a;
        end else if (op == 3'b011 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          p_lo = 32'h8000_0000; p_hi = 0;
        end else if (op == 3'b011) begin
          p_lo = 32'(int'(a) / int'(b)); p_hi = 32'(int'(a) % int'(b));
        end else begin
          p_lo = a / b; p_hi = a % b;
        end
      end
    endcase
  endtask

  // Issue one E-stage instruction at a negedge and hold it until it leaves EX.
  task automatic ins(input logic [3:0] ac, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [1:0] fa, input logic [1:0] fb,
                     input logic asrc, input logic rw);
    exp_t        e;
    logic        st, launch;
    logic [31:0] va, vb, sbv;
    n_instr++;
    rd1_E = a; rd2_E = b; forwardA_E = fa; forwardB_E = fb; alusrc_E = asrc;
    alucontrol_E = ac; md_op_E = op; regwrite_E = rw;
    memwrite_E = a[0]; memtoreg_E = b[1]; regdst_E = n_instr[0];
    rd_E = 5'(n_instr); rt_E = 5'd9;
    for (int guard = 0; guard < 100; guard++) begin
      st = (md_left > 0) && (op inside {[3'd1:3'd6]});
      #1;
      chk("md_stall", 32'(md_stall), 32'(st));
      chk("md_busy", 32'(md_busy), 32'(md_left > 0));
      va = (fa == 2'b01) ? result_W : (fa == 2'b10) ? m_alu : a;
      vb = (fb == 2'b01) ? result_W : (fb == 2'b10) ? m_alu : b;
      sbv = asrc ? signimm_E : vb;
      if (st) begin
        e.alu = m_alu; e.wd = m_wd; e.wr = m_wr; e.rw = 0; e.mw = 0; e.mt = 0;
      end else begin
        e.alu = (op == 3'b101) ? m_hi : (op == 3'b110) ? m_lo : alu_model(ac, va, sbv);
        e.wd = vb; e.wr = regdst_E ? rd_E : rt_E; e.rw = rw; e.mw = memwrite_E; e.mt = memtoreg_E;
      end
      sb.push_back(e);
      launch = (md_left == 0) && (op inside {[3'd1:3'd4]});
      @(posedge clk);
      if (md_left > 0) begin
        md_left--;
        if (md_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (launch) begin
        md_model(op, va, vb);
      end
      #1;
      e = sb.pop_front();
      chk("aluout_M", aluout_M, e.alu);
      chk("writedata_M", writedata_M, e.wd);
      chk("writereg_M", 32'(writereg_M), 32'(e.wr));
      chk("regwrite_M", 32'(regwrite_M), 32'(e.rw));
      chk("memwrite_M", 32'(memwrite_M), 32'(e.mw));
      chk("memtoreg_M", 32'(memtoreg_M), 32'(e.mt));
      m_alu = e.alu; m_wd = e.wd; m_wr = e.wr;
      @(negedge clk);
      if (!st) break;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst md_busy", 32'(md_busy), 32'd0);
    chk("rst md_stall", 32'(md_stall), 32'd0);
    chk("rst aluout_M", aluout_M, 32'd0);
    chk("rst writedata_M", writedata_M, 32'd0);
    chk("rst writereg_M", 32'(writereg_M), 32'd0);
    chk("rst ctrl_M", 32'({regwrite_M, memwrite_M, memtoreg_M}), 32'd0);
    md_left = 0; m_hi = 0; m_lo = 0; m_alu = 0; m_wd = 0; m_wr = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rd1_E = 0; rd2_E = 0; signimm_E = 32'h0000_0010; result_W = 0;
    forwardA_E = 0; forwardB_E = 0; alucontrol_E = 0; alusrc_E = 0; regdst_E = 0;
    rt_E = 0; rd_E = 0; regwrite_E = 1; memwrite_E = 1; memtoreg_E = 1; md_op_E = 0;
    @(negedge clk);
    do_reset();

    // forwarding
    ins(A_ADD, 3'b000, 32'd7, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b000, 32'd0, 32'd3, 2'b10, 2'b00, 1'b0, 1'b1);
    result_W = 32'd4;
    ins(A_ADD, 3'b000, 32'd0, 32'd3, 2'b01, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b000, 32'd5, 32'd3, 2'b11, 2'b00, 1'b0, 1'b1);
    ins(A_SUB, 3'b000, 32'd1, 32'd0, 2'b00, 2'b01, 1'b0, 1'b1);
    ins(A_ADD, 3'b000, 32'd5, 32'd99, 2'b00, 2'b00, 1'b1, 1'b1);

    // multiply, then HI/LO readers
    ins(A_ADD, 3'b001, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b110, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("mflo after mult", aluout_M, 32'hFFFF_FFFE);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("mfhi after mult", aluout_M, 32'hFFFF_FFFF);
    ins(A_ADD, 3'b010, 32'hFFFF_FFFF, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);

    // divides
    ins(A_ADD, 3'b100, 32'd100, 32'd7, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b110, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("divu lo", aluout_M, 32'd14);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b011, 32'hFFFF_FFF9, 32'd2, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b110, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("div rem neg", aluout_M, 32'hFFFF_FFFF);
    ins(A_ADD, 3'b011, 32'd12, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b000, 32'd20, 32'd22, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b110, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("div0 hi", aluout_M, 32'd12);
    ins(A_ADD, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 2'b00, 1'b0, 1'b0);
    ins(A_ADD, 3'b110, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("div ovf lo", aluout_M, 32'h8000_0000);
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);

    // reset in the middle of a divu
    ins(A_ADD, 3'b100, 32'd1000, 32'd3, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      ins(A_XOR, 3'b000, 32'(i * 5), 32'h55, 2'b00, 2'b00, 1'b0, 1'b1);
    do_reset();
    ins(A_ADD, 3'b101, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("mfhi after reset", aluout_M, 32'd0);

    // ALU corners
    ins(A_SLT, 3'b000, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("slt", aluout_M, 32'd1);
    ins(A_SLTU, 3'b000, 32'hFFFF_FFFF, 32'd1, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("sltu", aluout_M, 32'd0);
    ins(A_NOR, 3'b000, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(4'b1111, 3'b000, 32'h1234, 32'h5678, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_AND, 3'b000, 32'hF0F0, 32'hFF00, 2'b00, 2'b00, 1'b0, 1'b1);
    ins(A_OR, 3'b111, 32'hF0F0, 32'h0F0F, 2'b00, 2'b00, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
